// File: rtl/mux_scanner.sv
// Registered N-channel multiplexer with a manual/scan sequencer and a
// valid/ready output port tagged with the source channel index.
module mux_scanner #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 32,
  parameter int SEL_W    = 6,
  parameter int DWELL    = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [WIDTH*CHANNELS-1:0] data,
  input  logic [SEL_W-1:0]          select,
  input  logic                      mode,
  input  logic                      start,
  output logic [WIDTH-1:0]          q,
  output logic [SEL_W-1:0]          q_chan,
  output logic                      q_valid,
  input  logic                      q_ready,
  output logic                      busy,
  output logic                      done,
  output logic                      sel_err
);

  localparam int IDX_W = $clog2(CHANNELS);
  localparam int GAP_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = (DWELL > 0) ? GAP_W'(DWELL - 1) : '0;
  localparam logic [SEL_W-1:0] LAST_CH  = SEL_W'(CHANNELS - 1);
  localparam int unsigned CH_U = CHANNELS;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SAMPLE = 2'd1,
    HOLD   = 2'd2,
    GAP    = 2'd3
  } state_t;

  state_t           state_q;
  logic             mode_q;
  logic [SEL_W-1:0] cur_sel_q;
  logic [GAP_W-1:0] gap_cnt_q;

  // Unpack the flat bus; pad to a power of two so any low-order index is legal.
  logic [WIDTH-1:0] chan [2**IDX_W];
  genvar gi;
  generate
    for (gi = 0; gi < 2**IDX_W; gi++) begin : g_chan
      if (gi < CHANNELS) begin : g_real
        assign chan[gi] = data[gi*WIDTH +: WIDTH];
      end else begin : g_pad
        assign chan[gi] = '0;
      end
    end
  endgenerate

  logic sel_oob;
  assign sel_oob = (32'(cur_sel_q) >= CH_U);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      mode_q    <= 1'b0;
      cur_sel_q <= '0;
      gap_cnt_q <= '0;
      q         <= '0;
      q_chan    <= '0;
      q_valid   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      sel_err   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            mode_q    <= mode;
            cur_sel_q <= mode ? '0 : select;
            sel_err   <= 1'b0;
            busy      <= 1'b1;
            state_q   <= SAMPLE;
          end
        end
        SAMPLE: begin
          if (sel_oob) begin
            sel_err <= 1'b1;
            done    <= 1'b1;
            busy    <= 1'b0;
            state_q <= IDLE;
          end else begin
            q       <= chan[cur_sel_q[IDX_W-1:0]];
            q_chan  <= cur_sel_q;
            q_valid <= 1'b1;
            state_q <= HOLD;
          end
        end
        HOLD: begin
          if (q_ready) begin
            q_valid <= 1'b0;
            if (!mode_q || cur_sel_q == LAST_CH) begin
              done    <= 1'b1;
              busy    <= 1'b0;
              state_q <= IDLE;
            end else begin
              cur_sel_q <= cur_sel_q + SEL_W'(1);
              gap_cnt_q <= '0;
              state_q   <= (DWELL > 0) ? GAP : SAMPLE;
            end
          end
        end
        GAP: begin
          if (gap_cnt_q == GAP_LAST) begin
            state_q <= SAMPLE;
          end else begin
            gap_cnt_q <= gap_cnt_q + GAP_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
